// File: rtl/instruction_fetch_if.sv
// Instruction memory request/response bus between the fetch unit and memory.
interface instruction_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: a single-outstanding memory requester feeding a
// two-entry {pc, instr} queue whose head is presented to decode. Decode may
// redirect on the presented instruction; the instruction after it (the delay
// slot) is always kept, and everything fetched beyond it is discarded.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    instruction_fetch_if.master        imem,
    input  logic                       stall,
    input  logic                       jump_branch,
    input  logic                       jump_target,
    input  logic                       jump_reg,
    input  logic [31:0]                jr_pc,
    output logic [31:0]                pc_id,
    output logic [31:0]                instr_id,
    output logic                       instr_valid
);

    // Control state (reset)
    logic        run;
    logic [1:0]  count, count_n;
    logic        out_valid, out_valid_n;
    logic        out_dead, out_dead_n;
    logic [31:0] fetch_pc, fetch_pc_n;
    logic        redirect_pending, redirect_pending_n;

    // Data state (no reset; only meaningful while the matching control bit is set)
    logic [31:0] head_pc, head_pc_n, head_instr, head_instr_n;
    logic [31:0] tail_pc, tail_pc_n, tail_instr, tail_instr_n;
    logic [31:0] out_pc, out_pc_n;
    logic [31:0] redirect_target, redirect_target_n;

    logic [31:0] slot_pc;
    logic [31:0] target;
    logic        accept, redirect, req_fire, resp, push;

    // Conditional branch: offset is a signed word count relative to the delay slot.
    function automatic logic [31:0] branch_dest(input logic [31:0] next_pc,
                                                input logic [31:0] instr);
        logic signed [31:0] offset;
        offset = {{14{instr[15]}}, instr[15:0], 2'b00};
        return next_pc + $unsigned(offset);
    endfunction

    // Absolute jump within the 256 MB region of the delay slot.
    function automatic logic [31:0] jump_dest(input logic [31:0] next_pc,
                                              input logic [31:0] instr);
        return {next_pc[31:28], instr[25:0], 2'b00};
    endfunction

    assign instr_valid = (count != 2'd0);
    assign pc_id       = instr_valid ? head_pc : 32'h0;
    assign instr_id    = instr_valid ? head_instr : 32'h0;

    assign imem.imem_req  = run && !out_valid && (count != 2'd2);
    assign imem.imem_addr = fetch_pc;

    assign slot_pc  = head_pc + 32'd4;
    assign accept   = instr_valid && !stall;
    assign redirect = accept && (jump_branch || jump_target || jump_reg);
    assign target   = jump_reg    ? jr_pc :
                      jump_target ? jump_dest(slot_pc, head_instr) :
                                    branch_dest(slot_pc, head_instr);
    assign req_fire = imem.imem_req && imem.imem_ack;
    assign resp     = out_valid && imem.imem_rvalid;
    // A response survives only if it is live and, on a redirect, is the delay slot.
    assign push     = resp && !out_dead && !(redirect && (out_pc != slot_pc));

    // Queue next state: pop the head on accept (dropping a non-delay-slot tail on redirect), then push.
    always_comb begin
        count_n      = count;
        head_pc_n    = head_pc;
        head_instr_n = head_instr;
        tail_pc_n    = tail_pc;
        tail_instr_n = tail_instr;
        if (accept) begin
            if ((count == 2'd2) && (!redirect || (tail_pc == slot_pc))) begin
                head_pc_n    = tail_pc;
                head_instr_n = tail_instr;
                count_n      = 2'd1;
            end else begin
                count_n = 2'd0;
            end
        end
        if (push) begin
            if (count_n == 2'd0) begin
                head_pc_n    = out_pc;
                head_instr_n = imem.imem_rdata;
            end else begin
                tail_pc_n    = out_pc;
                tail_instr_n = imem.imem_rdata;
            end
            count_n = count_n + 2'd1;
        end
    end

    // Fetch address and outstanding-request tracking, including deferred redirects.
    always_comb begin
        fetch_pc_n         = fetch_pc;
        redirect_pending_n = redirect_pending;
        redirect_target_n  = redirect_target;
        out_valid_n        = out_valid;
        out_dead_n         = out_dead;
        out_pc_n           = out_pc;

        if (redirect) begin
            // Delay slot already requested (earlier, or accepted this very cycle): jump now.
            if ((fetch_pc != slot_pc) || req_fire) begin
                fetch_pc_n = target;
            end else begin
                redirect_pending_n = 1'b1;
                redirect_target_n  = target;
            end
        end else if (req_fire) begin
            if (redirect_pending) begin
                fetch_pc_n         = redirect_target;
                redirect_pending_n = 1'b0;
            end else begin
                fetch_pc_n = fetch_pc + 32'd4;
            end
        end

        if (resp) begin
            out_valid_n = 1'b0;
        end
        if (redirect && out_valid && (out_pc != slot_pc)) begin
            out_dead_n = 1'b1;
        end
        if (req_fire) begin
            out_valid_n = 1'b1;
            out_pc_n    = fetch_pc;
            out_dead_n  = redirect && (fetch_pc != slot_pc);
        end
    end

    // Control registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run              <= 1'b0;
            count            <= 2'd0;
            out_valid        <= 1'b0;
            out_dead         <= 1'b0;
            fetch_pc         <= RESET_PC;
            redirect_pending <= 1'b0;
        end else begin
            run              <= 1'b1;
            count            <= count_n;
            out_valid        <= out_valid_n;
            out_dead         <= out_dead_n;
            fetch_pc         <= fetch_pc_n;
            redirect_pending <= redirect_pending_n;
        end
    end

    // Data registers; validity is carried by the control registers above.
    always_ff @(posedge clk) begin
        head_pc         <= head_pc_n;
        head_instr      <= head_instr_n;
        tail_pc         <= tail_pc_n;
        tail_instr      <= tail_instr_n;
        out_pc          <= out_pc_n;
        redirect_target <= redirect_target_n;
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus randomized traffic
// compared against a program-order reference model.
module tb_instruction_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall, jump_branch, jump_target, jump_reg;
    logic [31:0] jr_pc, pc_id, instr_id;
    logic        instr_valid;

    instruction_fetch_if bus ();

    instruction_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (bus),
        .stall       (stall),
        .jump_branch (jump_branch),
        .jump_target (jump_target),
        .jump_reg    (jump_reg),
        .jr_pc       (jr_pc),
        .pc_id       (pc_id),
        .instr_id    (instr_id),
        .instr_valid (instr_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // reference model: architectural program order
    logic [31:0] exp_pc, pend_t;
    bit          has_pend;

    // stimulus knobs
    bit          hash_mode, rand_redirect;
    int          stall_pct, ack_pct, lat_max, forced_stall;
    logic [31:0] stall_at_pc, hold_pc;
    bit          stall_armed, hold_armed;
    logic [31:0] plan_pc [3];
    int          plan_kind [3];
    logic [31:0] plan_jr [3];
    bit          plan_used [3];
    int          n_plan;

    // logs and memory model
    logic [31:0] acc_log [$];
    logic [31:0] ack_log [$];
    int          acc_cyc [$];
    int          cyc, last_acc;
    bit          mem_busy;
    logic [31:0] mem_a;
    int          mem_wait;
    bit          prev_req, prev_ack;
    logic [31:0] prev_addr;

    logic [31:0] exp_a [8]  = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h24, 32'h28};
    logic [31:0] exp_b [5]  = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    logic [31:0] exp_c [15] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h1C,
                                32'h20, 32'h24, 32'h100, 32'h104, 32'h3000_0040,
                                32'h3000_0044, 32'h3000_0040};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (hash_mode) return a * 32'h9E37_79B1 + 32'h7F4A_7C15;
        if (a == 32'h10) return 32'h1000_0004;
        if (a == 32'h3000_0040) return 32'h0000_0010;
        return a;
    endfunction

    function automatic logic [31:0] model_target(input int kind, input logic [31:0] pc,
                                                 input logic [31:0] jr);
        logic [31:0] ins, nxt;
        ins = mem_word(pc);
        nxt = pc + 32'd4;
        case (kind)
            1:       return nxt + {{14{ins[15]}}, ins[15:0], 2'b00};
            2:       return {nxt[31:28], ins[25:0], 2'b00};
            default: return jr;
        endcase
    endfunction

    task automatic model_init();
        exp_pc = RESET_PC;
        has_pend = 1'b0;
        mem_busy = 1'b0;
        prev_req = 1'b0;
        prev_ack = 1'b0;
        forced_stall = 0;
        cyc = 0;
        last_acc = 0;
        acc_log.delete();
        ack_log.delete();
        acc_cyc.delete();
        for (int i = 0; i < 3; i++) plan_used[i] = 1'b0;
    endtask

    // One clock cycle: check outputs, drive decode and memory, advance the model.
    task automatic step();
        bit          acc;
        int          kind;
        logic [31:0] jr;
        cyc++;
        if (prev_req && !prev_ack) begin
            chk("req_held", {31'b0, bus.imem_req}, 32'd1);
            chk("addr_held", bus.imem_addr, prev_addr);
        end
        if (mem_busy) chk("one_outstanding", {31'b0, bus.imem_req}, 32'd0);
        if (!instr_valid) chk("nop_when_invalid", instr_id, 32'd0);

        if (stall_armed && instr_valid && (pc_id == stall_at_pc)) begin
            forced_stall = 5;
            stall_armed = 1'b0;
        end
        if (forced_stall > 0) begin
            stall = 1'b1;
            chk("stall_frozen_pc", pc_id, stall_at_pc);
            chk("stall_frozen_instr", instr_id, mem_word(stall_at_pc));
            if (forced_stall == 1) chk("stall_full_no_req", {31'b0, bus.imem_req}, 32'd0);
            forced_stall--;
        end else begin
            stall = ($urandom_range(99) < stall_pct);
        end

        acc = instr_valid && !stall;
        jump_branch = 1'b0;
        jump_target = 1'b0;
        jump_reg = 1'b0;
        jr_pc = $urandom & 32'hFFFF_FFFC;
        if (!acc && rand_redirect) begin
            jump_branch = 1'($urandom);
            jump_target = 1'($urandom);
            jump_reg = 1'($urandom);
        end
        if (acc) begin
            chk("pc_id", pc_id, exp_pc);
            chk("instr_id", instr_id, mem_word(exp_pc));
            acc_log.push_back(pc_id);
            acc_cyc.push_back(cyc);
            last_acc = cyc;
            kind = 0;
            jr = jr_pc;
            for (int i = 0; i < n_plan; i++) begin
                if (!plan_used[i] && plan_pc[i] == exp_pc) begin
                    kind = plan_kind[i];
                    jr = plan_jr[i];
                    plan_used[i] = 1'b1;
                end
            end
            if (kind == 0 && rand_redirect && $urandom_range(3) == 0) kind = int'($urandom_range(3, 1));
            if (has_pend) kind = 0;
            jr_pc = jr;
            case (kind)
                1: jump_branch = 1'b1;
                2: begin jump_target = 1'b1; jump_branch = 1'($urandom); end
                3: begin jump_reg = 1'b1; jump_target = 1'($urandom); jump_branch = 1'($urandom); end
                default: ;
            endcase
            if (kind != 0) begin
                pend_t = model_target(kind, exp_pc, jr);
                exp_pc = exp_pc + 32'd4;
                has_pend = 1'b1;
            end else if (has_pend) begin
                exp_pc = pend_t;
                has_pend = 1'b0;
            end else begin
                exp_pc = exp_pc + 32'd4;
            end
        end
        if (cyc - last_acc > 80) begin
            chk("progress", 32'(cyc - last_acc), 32'd0);
            last_acc = cyc;
        end

        bus.imem_rvalid = 1'b0;
        bus.imem_rdata = $urandom;
        if (mem_busy) begin
            if (mem_wait == 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata = mem_word(mem_a);
                mem_busy = 1'b0;
            end else begin
                mem_wait--;
            end
        end
        bus.imem_ack = 1'b0;
        if (bus.imem_req) begin
            if (hold_armed && instr_valid && pc_id == hold_pc) hold_armed = 1'b0;
            else bus.imem_ack = ($urandom_range(99) < ack_pct);
        end
        if (bus.imem_ack) begin
            mem_busy = 1'b1;
            mem_a = bus.imem_addr;
            mem_wait = int'($urandom_range(lat_max - 1));
            ack_log.push_back(bus.imem_addr);
        end
        prev_req = bus.imem_req;
        prev_addr = bus.imem_addr;
        prev_ack = bus.imem_ack;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        jump_branch = 1'b0;
        jump_target = 1'b0;
        jump_reg = 1'b0;
        jr_pc = 32'h0;
        bus.imem_ack = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
        chk("rst_pc_id", pc_id, 32'd0);
        chk("rst_instr_id", instr_id, 32'd0);
        rst_n = 1'b1;
        model_init();
        @(negedge clk);
        chk("first_req", {31'b0, bus.imem_req}, 32'd1);
        chk("first_addr", bus.imem_addr, RESET_PC);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        stall_armed = 1'b0;
        hold_armed = 1'b0;
        stall_at_pc = 32'h0;
        hold_pc = 32'h0;
        n_plan = 0;
        model_init();

        // sequential fetch at full rate, then a taken branch at 0x10
        hash_mode = 1'b0; rand_redirect = 1'b0; stall_pct = 0; ack_pct = 100; lat_max = 1;
        n_plan = 1; plan_pc[0] = 32'h10; plan_kind[0] = 1; plan_jr[0] = 32'h0;
        do_reset();
        for (int i = 0; i < 60 && acc_log.size() < 8; i++) step();
        for (int i = 0; i < 8; i++)
            chk("seq_branch_order", (i < acc_log.size()) ? acc_log[i] : 32'hFFFF_FFFF, exp_a[i]);
        for (int i = 0; i < 3; i++)
            chk("rate_le_2", {31'b0, (i + 1 < acc_cyc.size()) && (acc_cyc[i + 1] - acc_cyc[i] <= 2)}, 32'd1);

        // five-cycle stall on 0x8 fills the queue; nothing lost afterwards
        n_plan = 0; stall_at_pc = 32'h8; stall_armed = 1'b1;
        do_reset();
        for (int i = 0; i < 60 && acc_log.size() < 5; i++) step();
        for (int i = 0; i < 5; i++)
            chk("stall_order", (i < acc_log.size()) ? acc_log[i] : 32'hFFFF_FFFF, exp_b[i]);
        chk("stall_queued_b2b", (acc_cyc.size() > 3) ? 32'(acc_cyc[3] - acc_cyc[2]) : 32'hFFFF_FFFF, 32'd1);

        // jump_reg with the delay slot unfetched, then jump_reg and a region jump
        n_plan = 3;
        plan_pc[0] = 32'h20;        plan_kind[0] = 3; plan_jr[0] = 32'h100;
        plan_pc[1] = 32'h100;       plan_kind[1] = 3; plan_jr[1] = 32'h3000_0040;
        plan_pc[2] = 32'h3000_0040; plan_kind[2] = 2; plan_jr[2] = 32'h0;
        hold_pc = 32'h20; hold_armed = 1'b1;
        do_reset();
        for (int i = 0; i < 120 && acc_log.size() < 15; i++) step();
        for (int i = 0; i < 15; i++)
            chk("jump_order", (i < acc_log.size()) ? acc_log[i] : 32'hFFFF_FFFF, exp_c[i]);
        chk("jr_req_slot", (ack_log.size() > 9) ? ack_log[9] : 32'hFFFF_FFFF, 32'h24);
        chk("jr_req_target", (ack_log.size() > 10) ? ack_log[10] : 32'hFFFF_FFFF, 32'h100);

        // reset while a request is outstanding; late responses ignored
        n_plan = 0; hash_mode = 1'b1; lat_max = 3;
        do_reset();
        for (int i = 0; i < 40 && !(mem_busy && mem_wait > 0); i++) step();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("async_rst_req", {31'b0, bus.imem_req}, 32'd0);
        chk("async_rst_pc", pc_id, 32'd0);
        bus.imem_ack = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req", {31'b0, bus.imem_req}, 32'd1);
        chk("post_rst_addr", bus.imem_addr, RESET_PC);
        chk("post_rst_valid", {31'b0, instr_valid}, 32'd0);
        @(negedge clk);
        chk("late_rvalid_ignored", {31'b0, instr_valid}, 32'd0);
        model_init();
        prev_req = 1'b1; prev_addr = RESET_PC;
        for (int i = 0; i < 40; i++) step();
        chk("post_rst_first_pc", (acc_log.size() > 0) ? acc_log[0] : 32'hFFFF_FFFF, RESET_PC);

        // randomized traffic against the program-order model
        for (int cfg = 0; cfg < 2; cfg++) begin
            rand_redirect = 1'b1;
            stall_pct = (cfg == 0) ? 30 : 10;
            ack_pct   = (cfg == 0) ? 60 : 95;
            lat_max   = (cfg == 0) ? 3 : 1;
            do_reset();
            for (int i = 0; i < 3000; i++) step();
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule
